audio_pll_reset_sequencer: RTL
==============================

# audio_pll_reset_sequencer

Reset and lock supervisor for the audio system PLL (50 MHz refclk in; 100, 10 and 25 MHz out). It runs in the 50 MHz refclk domain and drives the PLL reset input. It qualifies the PLL `locked` output, retries on lock timeout and holds the Nios/audio subsystem in reset until the clocks are stable. A lock loss during operation re-asserts system reset immediately and re-runs the sequence.

## Interface
Parameters:
- `RST_HOLD_CYCLES`, 1000: cycles `pll_rst` is held high per attempt (20 us at 50 MHz).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock-high cycles needed to qualify lock.
- `LOCK_TIMEOUT_CYCLES`, 50000: maximum cycles spent in WAIT_LOCK per attempt.
- `SYS_RST_DELAY`, 256: cycles between lock qualification and `sys_reset_n` release.
- `MAX_RETRIES`, 3: consecutive timeouts that cause FAULT.

Ports:
- `clk`  in  1: 50 MHz reference clock (same net as the PLL refclk).
- `reset_n`  in  1: asynchronous, active-low reset.
- `pll_locked`  in  1: PLL locked output; asynchronous to `clk`.
- `soft_reset_req`  in  1: single-cycle pulse that restarts the sequence from PLL_RST.
- `pll_rst`  out  1: active-high reset to the PLL.
- `sys_reset_n`  out  1: active-low reset to the downstream system.
- `ready`  out  1: high only in RUN.
- `fault`  out  1: high only in FAULT.
- `state`  out  3: current state encoding.
- `retry_count`  out  2: consecutive lock timeouts in the current bring-up.
- `lock_loss_count`  out  8: lock losses seen in RUN; saturates at 255.

## Operation
- `pll_locked` passes through a 2-FF synchronizer; `lock_s` is the synchronizer output. All decisions use `lock_s`.
- State encodings: PLL_RST=0, WAIT_LOCK=1, RELEASE=2, RUN=3, FAULT=4.
- **PLL_RST**: `pll_rst`=1, `sys_reset_n`=0. Stay exactly `RST_HOLD_CYCLES` cycles, then go to WAIT_LOCK. The stable counter and timeout counter clear on entry to WAIT_LOCK.
- **WAIT_LOCK**: `pll_rst`=0, `sys_reset_n`=0.
  - The stable counter increments while `lock_s`=1 and clears when `lock_s`=0.
  - When the stable counter reaches `LOCK_STABLE_CYCLES`, go to RELEASE.
  - Otherwise, when the timeout counter reaches `LOCK_TIMEOUT_CYCLES`, increment `retry_count`. If the new value equals `MAX_RETRIES`, go to FAULT; else go to PLL_RST.
  - If stable and timeout occur in the same cycle, stable wins.
- **RELEASE**: `pll_rst`=0, `sys_reset_n`=0. Stay `SYS_RST_DELAY` cycles, then go to RUN.
  - If `lock_s`=0 in any RELEASE cycle, go to PLL_RST. `retry_count` is unchanged and `lock_loss_count` is not incremented.
- **RUN**: `sys_reset_n`=1, `ready`=1, `retry_count` cleared.
  - If `lock_s`=0 in any cycle, go to PLL_RST and increment `lock_loss_count`, saturating at 255.
- **FAULT**: `pll_rst`=1, `sys_reset_n`=0, `fault`=1. Exit only via `reset_n` or `soft_reset_req`.
- **soft_reset_req**: honoured in every state and has priority over all other transitions in the same cycle. Next state is PLL_RST and `retry_count` clears. `lock_loss_count` is not cleared.
- All outputs are registered and are functions of the registered state.

## Timing
- Reset values: state=PLL_RST, `pll_rst`=1, `sys_reset_n`=0, `ready`=0, `fault`=0, `retry_count`=0, `lock_loss_count`=0. Synchronizer flops reset to 0.
- A `reset_n` assertion mid-sequence forces the reset values asynchronously. The sequence restarts with a full `RST_HOLD_CYCLES` hold.
- Cycle numbering: cycle k is the k-th rising edge after `reset_n` deasserts; cycle 0 is the first edge with reset released.
- PLL_RST covers cycles 0..RST_HOLD_CYCLES-1. `pll_rst` falls at edge RST_HOLD_CYCLES.
- Lock detect latency: a `pll_locked` rise is visible on `lock_s` 2 edges later. RELEASE is entered `LOCK_STABLE_CYCLES` edges after `lock_s` first becomes high.
- A lock loss in RUN produces `sys_reset_n`=0, `ready`=0 and `pll_rst`=1 on the edge after `lock_s` falls. That is 3 edges after the `pll_locked` fall.
- `sys_reset_n` deasserts synchronously to `clk` and asserts synchronously (registered). Downstream domains re-synchronize it locally.

## Test plan
Parameters for all scenarios: RST_HOLD=4, STABLE=8, TIMEOUT=32, SYS_RST_DELAY=4, MAX_RETRIES=2.
- **Normal bring-up**: `pll_locked` rises at cycle 6 and stays high.
  - `pll_rst`=1 for cycles 0..3 and 0 from cycle 4.
  - `lock_s`=1 from cycle 8; RELEASE at cycle 16.
  - `sys_reset_n`=1, `ready`=1 and `state`=3 from cycle 20.
- **Glitchy lock**: `pll_locked` toggles with 5-cycle high runs for 20 cycles, then stays high.
  - No RELEASE until 8 consecutive `lock_s`-high cycles; `retry_count` stays 0.
- **Timeout and fault**: `pll_locked` held 0.
  - The first timeout gives `retry_count`=1 and a return to PLL_RST.
  - The second timeout gives `state`=4, `fault`=1, `pll_rst`=1, `sys_reset_n`=0, held for more than 100 cycles.
  - A `soft_reset_req` pulse then gives `state`=0, `retry_count`=0, `fault`=0 on the next edge.
- **Lock loss in RUN**: from RUN, drop `pll_locked` for 1 cycle, then restore it.
  - 3 edges later: `sys_reset_n`=0, `pll_rst`=1, `lock_loss_count`=1.
  - The bring-up repeats and `ready` returns 1 with the same cycle offsets as Normal bring-up.
  - 256 lock losses leave `lock_loss_count`=255.
- **Simultaneous events**:
  - `soft_reset_req` on the same edge WAIT_LOCK times out gives PLL_RST with `retry_count`=0.
  - Stable count reaching 8 on the timeout edge gives RELEASE.
- **Async reset mid-RUN**: assert `reset_n` between edges.
  - All outputs take reset values immediately, without waiting for a clock edge.
  - `lock_loss_count`=0.

Source files
------------

// File: rtl/audio_pll_reset_sequencer.sv
// Audio PLL reset and lock supervisor: holds the PLL in reset, qualifies lock,
// retries on timeout and keeps the downstream system in reset until clocks are stable.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// PLL_RST   | pll_rst held high for RST_HOLD_CYCLES
// WAIT_LOCK | waiting for LOCK_STABLE_CYCLES consecutive lock_s, with timeout
// RELEASE   | lock qualified, sys_reset_n held low for SYS_RST_DELAY
// RUN       | clocks stable, system out of reset
// FAULT     | retries exhausted, PLL parked in reset until soft/hard reset
module audio_pll_reset_sequencer #(
    parameter int unsigned RST_HOLD_CYCLES     = 1000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned SYS_RST_DELAY       = 256,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       soft_reset_req,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state,
    output logic [1:0] retry_count,
    output logic [7:0] lock_loss_count
);

    localparam int unsigned TMR_MAX = (RST_HOLD_CYCLES > SYS_RST_DELAY) ? RST_HOLD_CYCLES : SYS_RST_DELAY;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned STB_W   = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned TO_W    = $clog2(LOCK_TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic               lock_meta_q, lock_s_q;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [STB_W-1:0]   stable_q, stable_d, stable_inc;
    logic [TO_W-1:0]    tout_q, tout_d, tout_inc;
    logic [1:0]         retry_q, retry_d, retry_inc;
    logic [7:0]         lloss_q, lloss_d;
    logic               pll_rst_q, pll_rst_d;
    logic               sys_reset_n_q, sys_reset_n_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;

    // The reset interval itself does not count toward the hold, so the timer
    // starts one higher than on a mid-sequence entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_PLL_RST;
            lock_meta_q   <= 1'b0;
            lock_s_q      <= 1'b0;
            tmr_q         <= TMR_W'(RST_HOLD_CYCLES);
            stable_q      <= '0;
            tout_q        <= '0;
            retry_q       <= '0;
            lloss_q       <= '0;
            pll_rst_q     <= 1'b1;
            sys_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            lock_meta_q   <= pll_locked;
            lock_s_q      <= lock_meta_q;
            tmr_q         <= tmr_d;
            stable_q      <= stable_d;
            tout_q        <= tout_d;
            retry_q       <= retry_d;
            lloss_q       <= lloss_d;
            pll_rst_q     <= pll_rst_d;
            sys_reset_n_q <= sys_reset_n_d;
            ready_q       <= ready_d;
            fault_q       <= fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        stable_d   = stable_q;
        tout_d     = tout_q;
        retry_d    = retry_q;
        lloss_d    = lloss_q;
        stable_inc = lock_s_q ? (stable_q + 1'b1) : '0;
        tout_inc   = tout_q + 1'b1;
        retry_inc  = retry_q + 2'd1;

        if (soft_reset_req) begin
            state_d = ST_PLL_RST;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    if (tmr_q == '0) state_d = ST_WAIT_LOCK;
                    else             tmr_d   = tmr_q - 1'b1;
                end
                ST_WAIT_LOCK: begin
                    stable_d = stable_inc;
                    tout_d   = tout_inc;
                    if (stable_inc == STB_W'(LOCK_STABLE_CYCLES)) begin
                        state_d = ST_RELEASE;
                    end else if (tout_inc == TO_W'(LOCK_TIMEOUT_CYCLES)) begin
                        retry_d = retry_inc;
                        state_d = (retry_inc == 2'(MAX_RETRIES)) ? ST_FAULT : ST_PLL_RST;
                    end
                end
                ST_RELEASE: begin
                    if (!lock_s_q)         state_d = ST_PLL_RST;
                    else if (tmr_q == '0)  state_d = ST_RUN;
                    else                   tmr_d   = tmr_q - 1'b1;
                end
                ST_RUN: begin
                    if (!lock_s_q) begin
                        state_d = ST_PLL_RST;
                        lloss_d = (lloss_q != 8'hFF) ? (lloss_q + 8'd1) : lloss_q;
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_PLL_RST;
            endcase
        end

        // Entry actions; a soft reset while already in PLL_RST restarts the hold.
        if ((state_d != state_q) || soft_reset_req) begin
            case (state_d)
                ST_PLL_RST:   tmr_d = TMR_W'(RST_HOLD_CYCLES - 1);
                ST_RELEASE:   tmr_d = TMR_W'(SYS_RST_DELAY - 1);
                ST_WAIT_LOCK: begin
                    stable_d = '0;
                    tout_d   = '0;
                end
                ST_RUN:       retry_d = '0;
                default:      tmr_d = tmr_q;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as state and never glitch.
    always_comb begin
        pll_rst_d     = (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
        sys_reset_n_d = (state_d == ST_RUN);
        ready_d       = (state_d == ST_RUN);
        fault_d       = (state_d == ST_FAULT);
    end

    assign pll_rst         = pll_rst_q;
    assign sys_reset_n     = sys_reset_n_q;
    assign ready           = ready_q;
    assign fault           = fault_q;
    assign state           = state_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = lloss_q;

endmodule
